// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared widths, memory access encodings and wait-FSM states
// for the MEM/WB stage and its load alignment helper.
package mem_wb_stage_pkg;
    localparam int CPU_WIDTH             = 32;
    localparam int REG_ADDR_WIDTH        = 5;
    localparam int MEM_ACCESS_TYPE_WIDTH = 3;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_NONE       = 3'd0;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_BYTE  = 3'd1;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_HALF  = 3'd2;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ_WORD  = 3'd3;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_BYTE = 3'd4;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_HALF = 3'd5;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE_WORD = 3'd6;
    typedef enum logic {ST_RUN, ST_WAIT_MEM} state_t;
    function automatic logic is_read(input logic [MEM_ACCESS_TYPE_WIDTH-1:0] t);
        return t == MEM_ACCESS_TYPE_READ_BYTE || t == MEM_ACCESS_TYPE_READ_HALF ||
               t == MEM_ACCESS_TYPE_READ_WORD;
    endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM bundle, dmem response, flush, stall request and
// write-back / forwarding taps of the MEM/WB stage.
// slave = the stage itself, master = the surrounding pipeline.
// instret exists only when MEM_WB_INSTRET_EN is defined.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;
    logic                             ex_mem_valid;
    logic                             ex_mem_reg_wen;
    logic [REG_ADDR_WIDTH-1:0]        ex_mem_reg_waddr;
    logic [CPU_WIDTH-1:0]             ex_mem_alu_result;
    logic [MEM_ACCESS_TYPE_WIDTH-1:0] ex_mem_mem_access_type;
    logic                             ex_mem_mem_sign_ext;
    logic [CPU_WIDTH-1:0]             dmem_rdata;
    logic                             dmem_rvalid;
    logic                             flush;
    logic                             mem_stall_req;
    logic                             reg_wen;
    logic [REG_ADDR_WIDTH-1:0]        reg_waddr;
    logic [CPU_WIDTH-1:0]             reg_wdata;
    logic [REG_ADDR_WIDTH-1:0]        wb_forward_addr;
    logic [CPU_WIDTH-1:0]             wb_forward_data;
    logic [CPU_WIDTH-1:0]             wb_forward_data_mem_rdata;
    logic [MEM_ACCESS_TYPE_WIDTH-1:0] mem_wb_mem_access_type;
    logic                             mem_wb_mem_sign_ext;
    logic                             load_fault;
`ifdef MEM_WB_INSTRET_EN
    logic [63:0]                      instret;
`endif
    modport slave (
        input  ex_mem_valid, ex_mem_reg_wen, ex_mem_reg_waddr, ex_mem_alu_result,
               ex_mem_mem_access_type, ex_mem_mem_sign_ext, dmem_rdata, dmem_rvalid, flush,
`ifdef MEM_WB_INSTRET_EN
        output instret,
`endif
        output mem_stall_req, reg_wen, reg_waddr, reg_wdata, wb_forward_addr, wb_forward_data,
               wb_forward_data_mem_rdata, mem_wb_mem_access_type, mem_wb_mem_sign_ext, load_fault
    );
    modport master (
        output ex_mem_valid, ex_mem_reg_wen, ex_mem_reg_waddr, ex_mem_alu_result,
               ex_mem_mem_access_type, ex_mem_mem_sign_ext, dmem_rdata, dmem_rvalid, flush,
`ifdef MEM_WB_INSTRET_EN
        input  instret,
`endif
        input  mem_stall_req, reg_wen, reg_waddr, reg_wdata, wb_forward_addr, wb_forward_data,
               wb_forward_data_mem_rdata, mem_wb_mem_access_type, mem_wb_mem_sign_ext, load_fault
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// mem_wb_stage_load_align: picks the byte/half lane of a raw load word and
// extends it to 32 bits; word reads and non-reads pass the word through.
// Ports: rdata_i raw word, addr_i byte offset, type_i access type,
// sign_ext_i extension select, data_o aligned result.
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [CPU_WIDTH-1:0]             rdata_i,
    input  logic [1:0]                       addr_i,
    input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] type_i,
    input  logic                             sign_ext_i,
    output logic [CPU_WIDTH-1:0]             data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b      = rdata_i[{addr_i, 3'b000} +: 8];
        h      = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = type_i == MEM_ACCESS_TYPE_READ_BYTE ? {{24{sign_ext_i & b[7]}}, b} :
                 type_i == MEM_ACCESS_TYPE_READ_HALF ? {{16{sign_ext_i & h[15]}}, h} : rdata_i;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with a wait FSM for late load data.
// Ports: clk, rst (sync, active-high), bus (mem_wb_stage_if.slave) carrying the
// EX/MEM bundle, dmem response, flush, stall request, regfile write port,
// forwarding taps and sticky load_fault.
// Parameters: LOAD_TIMEOUT wait cycles before a load faults; CNT_W counter width.
// Optional: MEM_WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_wb_stage_if.slave     bus
);
    state_t                           state_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             valid_q;
    logic                             wen_q;
    logic [REG_ADDR_WIDTH-1:0]        waddr_q;
    logic [CPU_WIDTH-1:0]             alu_q;
    logic [CPU_WIDTH-1:0]             rdata_q;
    logic [MEM_ACCESS_TYPE_WIDTH-1:0] type_q;
    logic                             sext_q;
    logic                             fault_q;
    logic                             is_load;
    logic                             timeout;
    logic                             capture;
    logic [CPU_WIDTH-1:0]             aligned;
    // A bundle is captured when no data is owed, when the data arrives, or when
    // the wait gives up; otherwise upstream is held. Stall is exactly "not capturing".
    always_comb begin
        is_load = bus.ex_mem_valid & is_read(bus.ex_mem_mem_access_type);
        timeout = state_q == ST_WAIT_MEM & ~bus.dmem_rvalid & cnt_q == CNT_W'(LOAD_TIMEOUT);
        capture = state_q == ST_RUN ? ~(is_load & ~bus.dmem_rvalid) : bus.dmem_rvalid | timeout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            type_q  <= MEM_ACCESS_TYPE_NONE;
            sext_q  <= 1'b0;
            fault_q <= 1'b0;
        end else if (bus.flush) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            type_q  <= MEM_ACCESS_TYPE_NONE;
        end else if (capture) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= bus.ex_mem_valid;
            wen_q   <= bus.ex_mem_reg_wen & ~timeout;
            waddr_q <= bus.ex_mem_reg_waddr;
            alu_q   <= bus.ex_mem_alu_result;
            rdata_q <= bus.dmem_rdata;
            type_q  <= bus.ex_mem_valid ? bus.ex_mem_mem_access_type : MEM_ACCESS_TYPE_NONE;
            sext_q  <= bus.ex_mem_mem_sign_ext;
            fault_q <= fault_q | timeout;
        end else begin
            state_q <= ST_WAIT_MEM;
            cnt_q   <= state_q == ST_RUN ? CNT_W'(1) : cnt_q + CNT_W'(1);
            valid_q <= 1'b0;
            type_q  <= MEM_ACCESS_TYPE_NONE;
        end
    end
`ifdef MEM_WB_INSTRET_EN
    logic [63:0] instret_q;
    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= '0;
        else if (~bus.flush & capture & bus.ex_mem_valid & ~timeout)
            instret_q <= instret_q + 64'd1;
    end
    assign bus.instret = instret_q;
`endif
    mem_wb_stage_load_align u_load_align (
        .rdata_i    (rdata_q),
        .addr_i     (alu_q[1:0]),
        .type_i     (type_q),
        .sign_ext_i (sext_q),
        .data_o     (aligned)
    );
    assign bus.mem_stall_req             = ~bus.flush & ~capture;
    assign bus.reg_wen                   = valid_q & wen_q & |waddr_q;
    assign bus.reg_waddr                 = waddr_q;
    assign bus.reg_wdata                 = is_read(type_q) ? aligned : alu_q;
    assign bus.wb_forward_addr           = bus.reg_wen ? waddr_q : '0;
    assign bus.wb_forward_data           = alu_q;
    assign bus.wb_forward_data_mem_rdata = rdata_q;
    assign bus.mem_wb_mem_access_type    = type_q;
    assign bus.mem_wb_mem_sign_ext       = sext_q;
    assign bus.load_fault                = fault_q;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the 5-stage RV32I core. Consumes the EX/MEM bundle and the data-memory read response, and registers them.
- Drives the register-file write port: reg_wen, reg_waddr, reg_wdata.
- Drives the WB-stage forwarding taps consumed by the register file: wb_forward_addr, wb_forward_data, wb_forward_data_mem_rdata, mem_wb_mem_access_type, mem_wb_mem_sign_ext.
- Holds the pipeline via a wait FSM when data memory answers a load late.

Parameters:
- LOAD_TIMEOUT, 255, max cycles spent in WAIT_MEM before the load is aborted with a fault.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > LOAD_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mem_valid  in  1  EX/MEM holds a live instruction.
- ex_mem_reg_wen  in  1  instruction writes rd.
- ex_mem_reg_waddr  in  REG_ADDR_WIDTH  rd.
- ex_mem_alu_result  in  CPU_WIDTH  ALU result, or effective address for loads/stores.
- ex_mem_mem_access_type  in  MEM_ACCESS_TYPE_WIDTH  MEM_ACCESS_TYPE_* code.
- ex_mem_mem_sign_ext  in  1  sign-extend the load.
- dmem_rdata  in  CPU_WIDTH  raw aligned 32-bit word from data memory.
- dmem_rvalid  in  1  dmem_rdata valid this cycle.
- flush  in  1  kill the instruction being captured.
- mem_stall_req  out  1  hold IF..MEM this cycle.
- reg_wen  out  1  register-file write enable.
- reg_waddr  out  REG_ADDR_WIDTH  write address.
- reg_wdata  out  CPU_WIDTH  write data.
- wb_forward_addr  out  REG_ADDR_WIDTH  rd of the WB instruction, 0 when not writing.
- wb_forward_data  out  CPU_WIDTH  registered alu_result.
- wb_forward_data_mem_rdata  out  CPU_WIDTH  registered raw load word.
- mem_wb_mem_access_type  out  MEM_ACCESS_TYPE_WIDTH  registered access type; NONE when the stage is invalid.
- mem_wb_mem_sign_ext  out  1  registered sign-extend flag.
- load_fault  out  1  sticky; set on load timeout.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all mem_wb_* registers 0, valid 0, access type MEM_ACCESS_TYPE_NONE, FSM RUN, wait counter 0, load_fault 0. Every output is 0 / NONE.
- is_load = ex_mem_valid & access type is one of READ_BYTE, READ_HALF, READ_WORD.
- FSM state RUN:
  - Not a load, or a load with dmem_rvalid=1: capture the EX/MEM bundle and dmem_rdata next edge; valid <= ex_mem_valid.
  - Load with dmem_rvalid=0: mem_stall_req=1 (combinational, same cycle); insert a bubble (valid <= 0); go to WAIT_MEM; cnt <= 1.
- FSM state WAIT_MEM: mem_stall_req=1 while EX/MEM is held upstream.
  - dmem_rvalid=1: capture the bundle plus rdata; mem_stall_req=0 that cycle; go to RUN.
  - Else, cnt == LOAD_TIMEOUT: load_fault <= 1; capture the bundle with reg_wen forced 0; go to RUN.
  - Else cnt++.
- Latency: one edge from EX/MEM to WB outputs for non-stalled instructions.
- Write-back outputs, combinational from the registers:
  - reg_wen = valid & mem_wb_reg_wen & (reg_waddr != 0).
  - reg_wdata:
    - READ_BYTE: byte lane alu_result[1:0] of the rdata word, sign- or zero-extended to 32 bits.
    - READ_HALF: half lane alu_result[1] of the rdata word, extended the same way.
    - READ_WORD: rdata.
    - Otherwise: alu_result.
- Forward taps:
  - wb_forward_addr = reg_wen ? reg_waddr : 0. x0 never matches, so an invalid stage never forwards.
  - wb_forward_data / wb_forward_data_mem_rdata are raw; the consumer performs its own lane extraction.
- Stores: access type is propagated, reg_wen=0, dmem_rvalid is ignored.
- Precedence: rst > flush > wait FSM. A flush in any state gives valid <= 0, FSM RUN, cnt 0, mem_stall_req=0 that cycle.
- load_fault is cleared only by rst.

Optional Feature:
- MEM_WB_INSTRET_EN:
  - Defined: adds a 64-bit instret output, cleared by rst, incremented on each edge where a valid non-faulted instruction is captured.
  - Undefined: neither the port nor the counter exists.

Decomposition:
- Shared package / defines.v holds:
  - CPU_WIDTH, REG_ADDR_WIDTH, MEM_ACCESS_TYPE_WIDTH.
  - The MEM_ACCESS_TYPE_* encodings, including NONE.
  - The FSM state encoding (ST_RUN, ST_WAIT_MEM).
- One sub-module, load_align: combinational lane select plus extension, from (rdata, addr[1:0], type, sign_ext) to 32-bit data. It is reusable by the regfile forwarding path.

Test Plan:
- addi-type instruction, rd=5, alu_result=0x1234 -> next cycle reg_wen=1, waddr=5, wdata=0x1234, wb_forward_addr=5.
- lb, addr=0x..02, rdata=0x80FF0000, sign_ext=1, dmem_rvalid=1 -> wdata=0xFFFFFFFF. Same with sign_ext=0 -> wdata=0x000000FF.
- lhu, addr[1]=1, rdata=0xBEEF0000 -> wdata=0x0000BEEF. lw to rd=0 -> reg_wen=0, wb_forward_addr=0.
- lw with dmem_rvalid low for 3 cycles, then high with 0xCAFEBABE:
  - mem_stall_req=1 for 3 cycles, then 0.
  - Exactly one write of 0xCAFEBABE.
  - No bubble is written.
- LOAD_TIMEOUT=4, dmem_rvalid held low -> load_fault=1 after 4 wait cycles, reg_wen=0, FSM back in RUN, stall drops.
- flush during WAIT_MEM, and rst mid-wait -> bubble captured, mem_stall_req=0 next cycle, counter 0. With MEM_WB_INSTRET_EN, instret increments only for valid non-faulted instructions.
